als_spi_reader: RTL and testbench

SPI read engine for the PmodALS ambient-light sensor (ADC081S021, 8-bit). It sits directly downstream of `clock_divider`: it consumes the divider's `o_div_clock` as a timing reference, not as a clock. It generates chip-select and SCLK, shifts in one 16-clock conversion frame, and presents the 8-bit light sample with a one-cycle valid strobe. All logic runs in the `i_clock` domain.

---
 rtl/als_spi_reader.sv | 124 ++++++++++++
 tb/tb_als_spi_reader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/als_spi_reader.sv
// SPI read engine for the PmodALS (ADC081S021): frames one 16-clock conversion
// timed by the clock_divider output and strobes the 8-bit light sample.
`timescale 1ns/1ps
module als_spi_reader #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       i_clock,
   input  logic       i_aresetn,
   input  logic       i_div_clock,
   input  logic       i_start,
   input  logic       i_miso,
   output logic       o_cs_n,
   output logic       o_sclk,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_busy,
   output logic [1:0] o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic                   div_q;
   logic [SYNC_STAGES-1:0] miso_sync_q;
   logic [15:0]            shift_q, shift_d, shift_next;
   logic [3:0]             bit_cnt_q, bit_cnt_d;
   logic                   cs_n_q, cs_n_d;
   logic                   sclk_q, sclk_d;
   logic [7:0]             data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   busy_q, busy_d;
   logic                   rise, fall, miso_s;

   // i_div_clock is already a flop in this domain, so a single delay gives both edges.
   assign rise   = i_div_clock & ~div_q;
   assign fall   = ~i_div_clock & div_q;
   assign miso_s = miso_sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      cs_n_d     = cs_n_q;
      sclk_d     = sclk_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      busy_d     = busy_q;
      shift_next = {shift_q[14:0], miso_s};
      case (state_q)
         ST_IDLE: begin
            cs_n_d = 1'b1;
            sclk_d = 1'b1;
            busy_d = 1'b0;
            if (i_start) begin
               state_d = ST_ALIGN;
               busy_d  = 1'b1;
            end
         end
         ST_ALIGN: begin
            if (rise) begin
               cs_n_d    = 1'b0;
               bit_cnt_d = 4'd0;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (fall) begin
               sclk_d = 1'b0;
            end else if (rise) begin
               sclk_d    = 1'b1;
               shift_d   = shift_next;
               bit_cnt_d = bit_cnt_q + 4'd1;
               // 16th rise: D7..D0 were sampled on rises 4..11.
               if (bit_cnt_q == 4'd15) begin
                  cs_n_d  = 1'b1;
                  data_d  = shift_next[12:5];
                  valid_d = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_aresetn) begin
      if (!i_aresetn) begin
         state_q     <= ST_IDLE;
         div_q       <= 1'b0;
         miso_sync_q <= '0;
         shift_q     <= 16'h0000;
         bit_cnt_q   <= 4'd0;
         cs_n_q      <= 1'b1;
         sclk_q      <= 1'b1;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= i_div_clock;
         miso_sync_q <= {miso_sync_q[SYNC_STAGES-2:0], i_miso};
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         cs_n_q      <= cs_n_d;
         sclk_q      <= sclk_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
      end
   end

   assign o_cs_n      = cs_n_q;
   assign o_sclk      = sclk_q;
   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_busy      = busy_q;
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_als_spi_reader.sv
// Bench for als_spi_reader: divide-by-8 clock model, ADC081S021 model and a
// scoreboard that checks every o_valid sample and frame shape.
`timescale 1ns/1ps
module tb_als_spi_reader;

   logic       i_clock;
   logic       i_aresetn;
   logic       i_div_clock;
   logic       i_start;
   logic       i_miso;
   logic       o_cs_n;
   logic       o_sclk;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_busy;
   logic [1:0] o_dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  exp_q[$];
   logic [15:0] adc_q[$];
   logic [15:0] adc_word;
   int          adc_idx;

   int vcount     = 0;
   int busy_falls = 0;

   als_spi_reader #(.SYNC_STAGES(2)) dut (
      .i_clock     (i_clock),
      .i_aresetn   (i_aresetn),
      .i_div_clock (i_div_clock),
      .i_start     (i_start),
      .i_miso      (i_miso),
      .o_cs_n      (o_cs_n),
      .o_sclk      (o_sclk),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_busy      (o_busy),
      .o_dbg_state (o_dbg_state)
   );

   // ---------------- clock / reset / divider ----------------
   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   // clock_divider with DIV_FACTOR = 8: toggles every 4 system cycles.
   logic [1:0] div_cnt;
   always @(posedge i_clock or negedge i_aresetn) begin
      if (!i_aresetn) begin
         div_cnt     <= 2'd0;
         i_div_clock <= 1'b0;
      end else if (div_cnt == 2'd3) begin
         div_cnt     <= 2'd0;
         i_div_clock <= ~i_div_clock;
      end else begin
         div_cnt <= div_cnt + 2'd1;
      end
   end

   // ---------------- ADC model ----------------
   // First bit presented after the first SCLK fall, so rise k samples word[16-k].
   always @(negedge o_cs_n) begin
      if (adc_q.size() > 0) adc_word = adc_q.pop_front();
      else adc_word = 16'h0000;
      adc_idx = 15;
   end

   always @(negedge o_sclk) begin
      if (!o_cs_n) begin
         #1;
         if (adc_idx >= 0) i_miso = adc_word[adc_idx];
         adc_idx = adc_idx - 1;
      end
   end

   // ---------------- check helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   logic prev_sclk = 1'b1, prev_cs = 1'b1, prev_valid = 1'b0, prev_busy = 1'b0;
   int   rise_cnt = 0, fall_cnt = 0, gap = 0, busy_run = 0;
   logic gap_valid = 1'b0;

   always @(negedge i_clock) begin
      if (!i_aresetn) begin
         prev_sclk  = 1'b1;
         prev_cs    = 1'b1;
         prev_valid = 1'b0;
         prev_busy  = 1'b0;
         rise_cnt   = 0;
         fall_cnt   = 0;
         gap        = 0;
         busy_run   = 0;
         gap_valid  = 1'b0;
      end else begin
         if (o_sclk && !prev_sclk && !prev_cs) rise_cnt++;
         if (!o_sclk && prev_sclk && !o_cs_n) fall_cnt++;
         if (o_cs_n) gap++;
         if (!o_cs_n && prev_cs) begin
            if (gap_valid) check_range("cs_high_gap", gap, 8, 1000000);
            gap      = 0;
            rise_cnt = 0;
            fall_cnt = 0;
         end
         if (prev_valid) check("valid_width", {31'd0, o_valid}, 32'd0);
         if (o_valid) begin
            vcount++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_valid: got data %0h expected no valid", o_data);
            end else begin
               check("data", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
            end
            check("cs_rise_with_valid", {30'd0, prev_cs, o_cs_n}, 32'd1);
            check("busy_drop_with_valid", {31'd0, o_busy}, 32'd0);
            check("sclk_rises", rise_cnt, 16);
            check("sclk_falls", fall_cnt, 16);
            gap_valid = 1'b1;
            gap       = 1;
         end
         if (o_busy) begin
            busy_run++;
         end else if (prev_busy) begin
            check_range("busy_length", busy_run, 128, 137);
            busy_run = 0;
            busy_falls++;
         end
         prev_sclk  = o_sclk;
         prev_cs    = o_cs_n;
         prev_valid = o_valid;
         prev_busy  = o_busy;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_start();
      @(negedge i_clock);
      i_start = 1'b1;
      @(negedge i_clock);
      i_start = 1'b0;
   endtask

   task automatic issue(input logic [2:0] lead, input logic [7:0] data,
                        input logic [4:0] trail, input bit expect_valid);
      adc_q.push_back({lead, data, trail});
      if (expect_valid) exp_q.push_back(data);
   endtask

   task automatic wait_valids(input string name, input int n, input int budget);
      int got = 0;
      int t   = 0;
      while (got < n && t < budget) begin
         @(negedge i_clock);
         t++;
         if (o_valid) got++;
      end
      check(name, got, n);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge i_clock);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int   lat;
      int   bad;
      int   v0;
      int   b0;
      int   t;
      int   rises;
      logic psclk;

      i_aresetn = 1'b1;
      i_start   = 1'b0;
      i_miso    = 1'b0;
      #2 i_aresetn = 1'b0;
      wait_cycles(4);

      check("rst_cs_n", {31'd0, o_cs_n}, 32'd1);
      check("rst_sclk", {31'd0, o_sclk}, 32'd1);
      check("rst_data", {24'd0, o_data}, 32'd0);
      check("rst_valid", {31'd0, o_valid}, 32'd0);
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_state", {30'd0, o_dbg_state}, 32'd0);

      // Idle levels after release, no start.
      i_aresetn = 1'b1;
      bad = 0;
      repeat (1000) begin
         @(negedge i_clock);
         if (o_cs_n !== 1'b1 || o_sclk !== 1'b1 || o_valid !== 1'b0) bad++;
      end
      check("idle_levels_bad_cycles", bad, 0);

      // Single read with latency measurement.
      issue(3'b000, 8'hA5, 5'b00000, 1'b1);
      pulse_start();
      lat = 1;
      while (!o_valid && lat < 400) begin
         @(negedge i_clock);
         lat++;
      end
      check_range("single_latency", lat, 129, 137);
      wait_cycles(20);

      // Continuous conversions with start held high.
      issue(3'b000, 8'h00, 5'b00000, 1'b1);
      issue(3'b000, 8'hFF, 5'b00000, 1'b1);
      issue(3'b000, 8'h3C, 5'b00000, 1'b1);
      @(negedge i_clock);
      i_start = 1'b1;
      wait_valids("continuous_valids", 3, 1500);
      i_start = 1'b0;
      wait_cycles(20);

      // Start pulsed again mid-frame must be ignored.
      v0 = vcount;
      b0 = busy_falls;
      issue(3'b000, 8'h5A, 5'b00000, 1'b1);
      pulse_start();
      t = 0;
      while (o_cs_n && t < 100) begin
         @(negedge i_clock);
         t++;
      end
      check("ignored_cs_low_seen", {31'd0, o_cs_n}, 32'd0);
      wait_cycles(40);
      pulse_start();
      wait_valids("ignored_one_valid", 1, 400);
      wait_cycles(300);
      check("ignored_valid_count", vcount - v0, 1);
      check("ignored_busy_runs", busy_falls - b0, 1);

      // Reset after the 6th SCLK rise of a frame.
      v0 = vcount;
      issue(3'b000, 8'hC3, 5'b00000, 1'b0);
      pulse_start();
      rises = 0;
      t     = 0;
      psclk = o_sclk;
      while (rises < 6 && t < 400) begin
         @(negedge i_clock);
         t++;
         if (o_sclk && !psclk && !o_cs_n) rises++;
         psclk = o_sclk;
      end
      check("reset_six_rises", rises, 6);
      i_aresetn = 1'b0;
      #1;
      check("midrst_cs_n", {31'd0, o_cs_n}, 32'd1);
      check("midrst_sclk", {31'd0, o_sclk}, 32'd1);
      check("midrst_busy", {31'd0, o_busy}, 32'd0);
      check("midrst_data", {24'd0, o_data}, 32'd0);
      check("midrst_valid", {31'd0, o_valid}, 32'd0);
      wait_cycles(5);
      i_aresetn = 1'b1;
      wait_cycles(200);
      check("midrst_no_valid", vcount - v0, 0);

      issue(3'b000, 8'h3C, 5'b00000, 1'b1);
      pulse_start();
      wait_valids("after_reset_read", 1, 400);
      wait_cycles(20);

      // Ones in leading and trailing positions must not leak into the sample.
      issue(3'b111, 8'h81, 5'b11111, 1'b1);
      pulse_start();
      wait_valids("boundary_read", 1, 400);
      wait_cycles(20);

      check("exp_q_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
